hazard_track_pipe: RTL and testbench
====================================

// Module: hazard_track_pipe
// PURPOSE
// - Producer side of the operand-forwarding network: carries destination tags (rd, regwrite,
//   memread) from ID through EX/MEM/WB and drives regwrite_mem/wr_mem/regwrite_wb/wr_wb to the
//   forwarding unit.
// - Detects load-use hazards the forwarding unit cannot cover. Freezes on data-memory wait.
//   Inserts bubbles on branch flush. Sits beside the ID/EX, EX/MEM and MEM/WB pipeline registers.
// PARAMETERS
// - REG_AW   5   register-index width (5 = 32 GPRs; x0 hard-wired zero)
// - CNT_W    32  perf-counter width (used only with HAZ_PERF_CNT_EN)
// PORTS
// - clk           in   1       pipeline clock, rising edge
// - rst_n         in   1       asynchronous, active-low reset
// - id_valid      in   1       ID stage holds a real instruction
// - id_rd         in   REG_AW  ID destination register
// - id_regwrite   in   1       ID instruction writes rd
// - id_memread    in   1       ID instruction is a load
// - id_rs1/id_rs2 in   REG_AW  ID source registers
// - id_use_rs1/2  in   1       ID instruction actually reads rs1 / rs2
// - flush_ex      in   1       branch taken in EX: kill the instruction entering EX
// - mem_busy      in   1       data memory not ready: freeze EX/MEM/WB tracking
// - regrd_ex      out  REG_AW  EX-stage rd
// - memread_ex    out  1       EX-stage instruction is a load
// - regwrite_mem  out  1       MEM-stage write enable (to forwarding)
// - wr_mem        out  REG_AW  MEM-stage rd (to forwarding)
// - regwrite_wb   out  1       WB-stage write enable (to forwarding)
// - wr_wb         out  REG_AW  WB-stage rd (to forwarding)
// - stall_if_id   out  1       hold PC and IF/ID this cycle
// - bubble_ex     out  1       ID/EX loads a NOP this cycle
// BEHAVIOUR
// - Reset (rst_n=0, async): all tag registers and all outputs clear to 0. A bubble is
//   rd=0, regwrite=0, memread=0.
// - The whole block is a registered 3-stage tag pipe; every tag output is driven straight
//   from a flop.
// - lu (comb) = id_valid & memread_ex & (regrd_ex!=0) &
//   ((id_use_rs1 & id_rs1==regrd_ex) | (id_use_rs2 & id_rs2==regrd_ex)).
// - Priority per cycle:
//   1. mem_busy=1 -> FREEZE: all tag regs hold. stall_if_id=1, bubble_ex=0.
//      flush_ex is ignored; its source holds it until mem_busy drops.
//   2. flush_ex=1 -> advance; ID/EX <= bubble. stall_if_id=0, bubble_ex=1.
//      lu is suppressed because the ID instruction is wrong-path.
//   3. lu=1 -> advance; ID/EX <= bubble. stall_if_id=1, bubble_ex=1.
//   4. else -> advance. ID/EX <= ID fields if id_valid, else bubble. stall/bubble=0.
// - Advance: MEM/WB <= EX/MEM, EX/MEM <= ID/EX, ID/EX per the rules above.
// - Latency in advancing cycles:
//   - an ID tag appears on regrd_ex after 1 edge, on wr_mem after 2, on wr_wb after 3.
//   - FREEZE cycles do not count.
// - Load-use stall lasts exactly 1 advancing cycle: the bubble removes memread_ex next cycle.
//   Data then comes from the WB forward path.
// - x0: a load to x0 never stalls. Tags with rd=0 pass through unchanged; the forwarding
//   unit filters them.
// - Reset mid-FREEZE or mid-stall: state is lost and all outputs read 0 on the next
//   sampled value.
// - stall_if_id and bubble_ex are combinational from the current state and inputs.
//   No registered handshake.
// CONFIGURATION
// - HAZ_PERF_CNT_EN defined: adds outputs lu_stall_cnt and freeze_cnt [CNT_W-1:0].
//   - lu_stall_cnt increments on each priority-3 cycle; freeze_cnt on each priority-1 cycle.
//   - Both wrap modulo 2^CNT_W and reset to 0.
// - HAZ_PERF_CNT_EN undefined: the ports and counters do not exist; all other behaviour is
//   identical.
// TESTING
// - Assert rst_n=0 mid-stream with regwrite tags in flight -> all outputs 0 immediately;
//   after release, bubbles flow.
// - ID {rd=5, regwrite=1, valid}, no hazards -> regrd_ex=5 after edge 1;
//   wr_mem=5, regwrite_mem=1 after edge 2; wr_wb=5, regwrite_wb=1 after edge 3.
// - Load x7 in EX, ID reads rs2=7 with use_rs2=1 -> stall_if_id=1, bubble_ex=1 for 1 cycle;
//   next cycle regrd_ex=0, memread_ex=0, stall_if_id=0; wr_mem=7.
// - Load x0 in EX, ID reads rs1=0 -> no stall. Load x7 in EX, ID rs1=7 with use_rs1=0 ->
//   no stall.
// - mem_busy high for 3 cycles with tags 3/4/5 in EX/MEM/WB -> tags hold, stall_if_id=1,
//   bubble_ex=0; freeze_cnt +3 when HAZ_PERF_CNT_EN is defined.
// - flush_ex=1 coincident with lu=1 -> bubble_ex=1, stall_if_id=0, lu_stall_cnt unchanged.

Source files
------------

// File: rtl/hazard_track_pipe_if.sv
// rtl/hazard_track_pipe_if.sv - ID-side tag inputs and forwarding/hazard outputs of hazard_track_pipe
//
// Purpose: bundles the destination/source tag inputs from ID, the flush/freeze
// controls, and the tag outputs consumed by the forwarding unit and the IF/ID
// stall logic.
// Modports:
//   master - pipeline control side (drives ID tags, flush_ex, mem_busy)
//   slave  - hazard_track_pipe (drives EX/MEM/WB tags, stall_if_id, bubble_ex)
// Parameter: REG_AW register-index width.

interface hazard_track_pipe_if #(
  parameter int REG_AW = 5
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rd;
  logic              id_regwrite;
  logic              id_memread;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic              flush_ex;
  logic              mem_busy;

  logic [REG_AW-1:0] regrd_ex;
  logic              memread_ex;
  logic              regwrite_mem;
  logic [REG_AW-1:0] wr_mem;
  logic              regwrite_wb;
  logic [REG_AW-1:0] wr_wb;
  logic              stall_if_id;
  logic              bubble_ex;

  modport master (
    output id_valid, id_rd, id_regwrite, id_memread,
           id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           flush_ex, mem_busy,
    input  regrd_ex, memread_ex, regwrite_mem, wr_mem,
           regwrite_wb, wr_wb, stall_if_id, bubble_ex
  );

  modport slave (
    input  id_valid, id_rd, id_regwrite, id_memread,
           id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           flush_ex, mem_busy,
    output regrd_ex, memread_ex, regwrite_mem, wr_mem,
           regwrite_wb, wr_wb, stall_if_id, bubble_ex
  );
endinterface

// File: rtl/hazard_track_pipe.sv
// rtl/hazard_track_pipe.sv - destination-tag pipe with load-use, flush and memory-wait hazard control
//
// Purpose: carries rd/regwrite/memread tags from ID through EX, MEM and WB for
// the forwarding unit, detects load-use hazards that forwarding cannot cover,
// freezes while data memory is busy and inserts bubbles on branch flush.
// Ports:
//   clk           pipeline clock, rising edge
//   rst_n         asynchronous active-low reset
//   bus           hazard_track_pipe_if.slave (ID tags in, EX/MEM/WB tags and
//                 stall_if_id/bubble_ex out)
//   lu_stall_cnt  load-use stall cycle count  (only with HAZ_PERF_CNT_EN)
//   freeze_cnt    memory-wait freeze count    (only with HAZ_PERF_CNT_EN)
// Optional feature macro: HAZ_PERF_CNT_EN (adds the two perf counters and CNT_W).

module hazard_track_pipe #(
  parameter int REG_AW = 5
`ifdef HAZ_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  hazard_track_pipe_if.slave bus
`ifdef HAZ_PERF_CNT_EN
  , output logic [CNT_W-1:0] lu_stall_cnt
  , output logic [CNT_W-1:0] freeze_cnt
`endif
);

  // ID/EX, EX/MEM, MEM/WB tag registers
  logic [REG_AW-1:0] ex_rd;
  logic              ex_regwrite;
  logic              ex_memread;
  logic [REG_AW-1:0] mem_rd;
  logic              mem_regwrite;
  logic [REG_AW-1:0] wb_rd;
  logic              wb_regwrite;

  logic lu;
  logic load_bubble;  // ID/EX takes a bubble instead of the ID fields

  // A load to x0 never produces a usable value, so it never needs a stall.
  assign lu = bus.id_valid & ex_memread & (ex_rd != '0) &
              ((bus.id_use_rs1 & (bus.id_rs1 == ex_rd)) |
               (bus.id_use_rs2 & (bus.id_rs2 == ex_rd)));

  assign load_bubble = bus.flush_ex | lu | ~bus.id_valid;

  // Freeze beats flush (the flush source holds until memory is ready), and
  // flush beats load-use because the ID instruction is wrong-path anyway.
  always_comb begin
    bus.stall_if_id = 1'b0;
    bus.bubble_ex   = 1'b0;
    if (rst_n) begin
      if (bus.mem_busy) begin
        bus.stall_if_id = 1'b1;
      end else if (bus.flush_ex) begin
        bus.bubble_ex = 1'b1;
      end else if (lu) begin
        bus.stall_if_id = 1'b1;
        bus.bubble_ex   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rd        <= '0;
      ex_regwrite  <= 1'b0;
      ex_memread   <= 1'b0;
      mem_rd       <= '0;
      mem_regwrite <= 1'b0;
      wb_rd        <= '0;
      wb_regwrite  <= 1'b0;
    end else if (!bus.mem_busy) begin
      wb_rd        <= mem_rd;
      wb_regwrite  <= mem_regwrite;
      mem_rd       <= ex_rd;
      mem_regwrite <= ex_regwrite;
      if (load_bubble) begin
        ex_rd       <= '0;
        ex_regwrite <= 1'b0;
        ex_memread  <= 1'b0;
      end else begin
        ex_rd       <= bus.id_rd;
        ex_regwrite <= bus.id_regwrite;
        ex_memread  <= bus.id_memread;
      end
    end
  end

  assign bus.regrd_ex     = ex_rd;
  assign bus.memread_ex   = ex_memread;
  assign bus.regwrite_mem = mem_regwrite;
  assign bus.wr_mem       = mem_rd;
  assign bus.regwrite_wb  = wb_regwrite;
  assign bus.wr_wb        = wb_rd;

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lu_stall_cnt <= '0;
      freeze_cnt   <= '0;
    end else begin
      if (bus.mem_busy) begin
        freeze_cnt <= freeze_cnt + 1'b1;
      end else if (!bus.flush_ex && lu) begin
        lu_stall_cnt <= lu_stall_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_track_pipe.sv
// tb/tb_hazard_track_pipe.sv - directed self-checking bench for hazard_track_pipe

module tb_hazard_track_pipe;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  hazard_track_pipe_if #(.REG_AW(5)) bus ();

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] lu_stall_cnt;
  logic [31:0] freeze_cnt;
  hazard_track_pipe dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .lu_stall_cnt (lu_stall_cnt),
    .freeze_cnt   (freeze_cnt)
  );
`else
  hazard_track_pipe dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic valid, input logic [4:0] rd, input logic rw,
                       input logic mr, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic flush,
                       input logic busy);
    bus.id_valid    = valid;
    bus.id_rd       = rd;
    bus.id_regwrite = rw;
    bus.id_memread  = mr;
    bus.id_rs1      = rs1;
    bus.id_rs2      = rs2;
    bus.id_use_rs1  = u1;
    bus.id_use_rs2  = u2;
    bus.flush_ex    = flush;
    bus.mem_busy    = busy;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Advance one edge and settle well past it before sampling.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".regrd_ex"},     32'(bus.regrd_ex),     32'd0);
    chk({tag, ".memread_ex"},   32'(bus.memread_ex),   32'd0);
    chk({tag, ".regwrite_mem"}, 32'(bus.regwrite_mem), 32'd0);
    chk({tag, ".wr_mem"},       32'(bus.wr_mem),       32'd0);
    chk({tag, ".regwrite_wb"},  32'(bus.regwrite_wb),  32'd0);
    chk({tag, ".wr_wb"},        32'(bus.wr_wb),        32'd0);
    chk({tag, ".stall_if_id"},  32'(bus.stall_if_id),  32'd0);
    chk({tag, ".bubble_ex"},    32'(bus.bubble_ex),    32'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    idle();

    // Reset state
    tick();
    tick();
    chk_all_zero("reset");
`ifdef HAZ_PERF_CNT_EN
    chk("reset.lu_cnt", lu_stall_cnt, 32'd0);
    chk("reset.frz_cnt", freeze_cnt, 32'd0);
`endif
    rst_n = 1'b1;

    // Latency: rd=5 -> EX after 1, MEM after 2, WB after 3
    drive(1'b1, 5'd5, 1'b1, 1'b0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk("lat.e1.regrd_ex", 32'(bus.regrd_ex), 32'd5);
    chk("lat.e1.memread_ex", 32'(bus.memread_ex), 32'd0);
    idle();
    tick();
    chk("lat.e2.wr_mem", 32'(bus.wr_mem), 32'd5);
    chk("lat.e2.regwrite_mem", 32'(bus.regwrite_mem), 32'd1);
    chk("lat.e2.regrd_ex", 32'(bus.regrd_ex), 32'd0);
    tick();
    chk("lat.e3.wr_wb", 32'(bus.wr_wb), 32'd5);
    chk("lat.e3.regwrite_wb", 32'(bus.regwrite_wb), 32'd1);
    chk("lat.e3.regwrite_mem", 32'(bus.regwrite_mem), 32'd0);

    // Load-use on rs2: load x7 in EX, ID (rd=8) reads x7
    drive(1'b1, 5'd7, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("lu.load.regrd_ex", 32'(bus.regrd_ex), 32'd7);
    chk("lu.load.memread_ex", 32'(bus.memread_ex), 32'd1);
    drive(1'b1, 5'd8, 1'b1, 1'b0, 5'd3, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("lu.stall", 32'(bus.stall_if_id), 32'd1);
    chk("lu.bubble", 32'(bus.bubble_ex), 32'd1);
    tick();
    chk("lu.next.regrd_ex", 32'(bus.regrd_ex), 32'd0);
    chk("lu.next.memread_ex", 32'(bus.memread_ex), 32'd0);
    chk("lu.next.wr_mem", 32'(bus.wr_mem), 32'd7);
    chk("lu.next.stall", 32'(bus.stall_if_id), 32'd0);
    chk("lu.next.bubble", 32'(bus.bubble_ex), 32'd0);
`ifdef HAZ_PERF_CNT_EN
    chk("lu.cnt", lu_stall_cnt, 32'd1);
`endif
    tick();
    chk("lu.retry.regrd_ex", 32'(bus.regrd_ex), 32'd8);

    // Load to x0 never stalls
    drive(1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("x0.memread_ex", 32'(bus.memread_ex), 32'd1);
    drive(1'b1, 5'd9, 1'b1, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("x0.stall", 32'(bus.stall_if_id), 32'd0);
    chk("x0.bubble", 32'(bus.bubble_ex), 32'd0);

    // Load x7 in EX, ID names rs1=7 but does not use it
    drive(1'b1, 5'd7, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd9, 1'b1, 1'b0, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("nouse.stall", 32'(bus.stall_if_id), 32'd0);
    chk("nouse.bubble", 32'(bus.bubble_ex), 32'd0);

    // Freeze with tags 3/4/5 in EX/MEM/WB (flush held alongside is ignored)
    drive(1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd4, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd9, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    #1;
    chk("frz.stall", 32'(bus.stall_if_id), 32'd1);
    chk("frz.bubble", 32'(bus.bubble_ex), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("frz%0d.regrd_ex", i), 32'(bus.regrd_ex), 32'd3);
      chk($sformatf("frz%0d.wr_mem", i), 32'(bus.wr_mem), 32'd4);
      chk($sformatf("frz%0d.wr_wb", i), 32'(bus.wr_wb), 32'd5);
    end
`ifdef HAZ_PERF_CNT_EN
    chk("frz.cnt", freeze_cnt, 32'd3);
`endif
    idle();
    tick();
    chk("thaw.regrd_ex", 32'(bus.regrd_ex), 32'd0);
    chk("thaw.wr_mem", 32'(bus.wr_mem), 32'd3);
    chk("thaw.wr_wb", 32'(bus.wr_wb), 32'd4);

    // Flush coincident with load-use: bubble without stall, no lu count
    drive(1'b1, 5'd7, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd10, 1'b1, 1'b0, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    #1;
    chk("flush.bubble", 32'(bus.bubble_ex), 32'd1);
    chk("flush.stall", 32'(bus.stall_if_id), 32'd0);
    tick();
    chk("flush.regrd_ex", 32'(bus.regrd_ex), 32'd0);
    chk("flush.memread_ex", 32'(bus.memread_ex), 32'd0);
`ifdef HAZ_PERF_CNT_EN
    chk("flush.lu_cnt", lu_stall_cnt, 32'd1);
`endif

    // Reset mid-freeze with regwrite tags in flight
    drive(1'b1, 5'd6, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    chk("prerst.wr_mem", 32'(bus.wr_mem), 32'd6);
    bus.mem_busy = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
`ifdef HAZ_PERF_CNT_EN
    chk("midrst.frz_cnt", freeze_cnt, 32'd0);
`endif
    idle();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk_all_zero("postrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
